// File: rtl/id_pkg.sv
// Shared types and constants for the decode stage and its ID/EX register.
package id_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // ID/EX fields are sized for the widest legal configuration; the top
    // truncates to XLEN / AW on the way out.
    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned AW_MAX   = 5;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] rd1;
        logic [XLEN_MAX-1:0] rd2;
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] pc;
        logic [AW_MAX-1:0]   rs1;
        logic [AW_MAX-1:0]   rs2;
        logic [AW_MAX-1:0]   rd;
        logic                regwrite;
        logic                load;
        logic                valid;
    } idex_t;

    // A bubble is fully deterministic: every field zero, valid cleared.
    localparam idex_t BUBBLE = '0;

endpackage

// File: rtl/regfile_bp.sv
// Register file: two combinational read ports, one synchronous write port,
// optional same-cycle write-to-read bypass, x0 hardwired to zero.
module regfile_bp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [XLEN-1:0]          rdata1_o,
    output logic [XLEN-1:0]          rdata2_o
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0] mem_q [NREGS];
    logic            wr_en;

    // Writes to x0 are dropped here so the array entry stays zero.
    assign wr_en = we_i && (waddr_i != '0);

    // Storage: clear on reset (a coinciding write is discarded), else write.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1: array value, optionally overridden by the in-flight write.
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        if ((BYPASS != 0) && wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (raddr1_i == AW'(0)) begin
            rdata1_o = '0;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rdata2_o = mem_q[raddr2_i];
        if ((BYPASS != 0) && wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
        if (raddr2_i == AW'(0)) begin
            rdata2_o = '0;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand read, immediate generation, load-use detection and
// the ID/EX pipeline register with flush/stall/bubble control.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              InstrD,
    input  logic [XLEN-1:0]          PCD,
    input  logic [2:0]               ImmSrcD,
    input  logic                     RegWriteD,
    input  logic                     LoadD,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREGS)-1:0] RdW,
    input  logic [XLEN-1:0]          ResultW,
    input  logic                     StallE,
    input  logic                     FlushE,
    output logic [XLEN-1:0]          RD1E,
    output logic [XLEN-1:0]          RD2E,
    output logic [XLEN-1:0]          ImmExtE,
    output logic [XLEN-1:0]          PCE,
    output logic [$clog2(NREGS)-1:0] Rs1E,
    output logic [$clog2(NREGS)-1:0] Rs2E,
    output logic [$clog2(NREGS)-1:0] RdE,
    output logic                     RegWriteE,
    output logic                     LoadE,
    output logic                     ValidE,
    output logic                     HazardStallD
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]       rs1;
    logic [AW-1:0]       rs2;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN_MAX-1:0] imm_full;
    logic [XLEN-1:0]     imm;
    idex_t               idex_d;
    idex_t               idex_q;
    logic                sgn;

    // With 16 registers the top index bit of each field is simply dropped.
    assign rs1 = InstrD[15 +: AW];
    assign rs2 = InstrD[20 +: AW];
    assign rd  = InstrD[7 +: AW];
    assign sgn = InstrD[31];

    regfile_bp #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk_i    (clk),
        .reset_i  (reset),
        .we_i     (RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Immediate generation at full width; unknown ImmSrcD codes decode as I.
    always_comb begin
        imm_full = {{52{sgn}}, InstrD[31:20]};
        case (imm_src_e'(ImmSrcD))
            IMM_S: imm_full = {{52{sgn}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_full = {{51{sgn}}, sgn, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: imm_full = {{43{sgn}}, sgn, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            IMM_U: imm_full = {{32{sgn}}, InstrD[31:12], 12'b0};
            default: imm_full = {{52{sgn}}, InstrD[31:20]};
        endcase
    end

    assign imm = imm_full[XLEN-1:0];

    // Conservative load-use check: any rs field match counts, even when the
    // instruction format does not actually read that register.
    assign HazardStallD = LoadE && ValidE && (RdE != '0) && ((RdE == rs1) || (RdE == rs2));

    // Next ID/EX contents: flush beats stall, stall beats the hazard bubble.
    always_comb begin
        idex_d = idex_q;
        if (FlushE) begin
            idex_d = BUBBLE;
        end else if (StallE) begin
            idex_d = idex_q;
        end else if (HazardStallD) begin
            idex_d = BUBBLE;
        end else begin
            idex_d          = BUBBLE;
            idex_d.rd1      = XLEN_MAX'(rd1);
            idex_d.rd2      = XLEN_MAX'(rd2);
            idex_d.imm      = XLEN_MAX'(imm);
            idex_d.pc       = XLEN_MAX'(PCD);
            idex_d.rs1      = AW_MAX'(rs1);
            idex_d.rs2      = AW_MAX'(rs2);
            idex_d.rd       = AW_MAX'(rd);
            idex_d.regwrite = RegWriteD;
            idex_d.load     = LoadD;
            idex_d.valid    = 1'b1;
        end
    end

    // ID/EX pipeline register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RD1E      = idex_q.rd1[XLEN-1:0];
    assign RD2E      = idex_q.rd2[XLEN-1:0];
    assign ImmExtE   = idex_q.imm[XLEN-1:0];
    assign PCE       = idex_q.pc[XLEN-1:0];
    assign Rs1E      = idex_q.rs1[AW-1:0];
    assign Rs2E      = idex_q.rs2[AW-1:0];
    assign RdE       = idex_q.rd[AW-1:0];
    assign RegWriteE = idex_q.regwrite;
    assign LoadE     = idex_q.load;
    assign ValidE    = idex_q.valid;

    // Upper struct bits (narrow configs) and the opcode field are not consumed.
    logic unused_bits;
    assign unused_bits = ^{idex_q.rd1, idex_q.rd2, idex_q.imm, idex_q.pc,
                           idex_q.rs1, idex_q.rs2, idex_q.rd, imm_full, InstrD[6:0]};

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: two instances (bypass on / off) share stimulus and
// are compared against a behavioural model of the decode stage.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, ResultW;
    logic [2:0]  ImmSrcD;
    logic        RegWriteD, LoadD, RegWriteW, StallE, FlushE;
    logic [4:0]  RdW;

    logic [31:0] rd1_a, rd2_a, imm_a, pc_a, rd1_b, rd2_b, imm_b, pc_b;
    logic [4:0]  rs1_a, rs2_a, rdx_a, rs1_b, rs2_b, rdx_b;
    logic        rw_a, ld_a, v_a, hz_a, rw_b, ld_b, v_b, hz_b;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut_bp (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .ImmSrcD(ImmSrcD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE), .RD1E(rd1_a), .RD2E(rd2_a),
        .ImmExtE(imm_a), .PCE(pc_a), .Rs1E(rs1_a), .Rs2E(rs2_a), .RdE(rdx_a),
        .RegWriteE(rw_a), .LoadE(ld_a), .ValidE(v_a), .HazardStallD(hz_a)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_dut_nobp (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .ImmSrcD(ImmSrcD),
        .RegWriteD(RegWriteD), .LoadD(LoadD), .RegWriteW(RegWriteW), .RdW(RdW),
        .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE), .RD1E(rd1_b), .RD2E(rd2_b),
        .ImmExtE(imm_b), .PCE(pc_b), .Rs1E(rs1_b), .Rs2E(rs2_b), .RdE(rdx_b),
        .RegWriteE(rw_b), .LoadE(ld_b), .ValidE(v_b), .HazardStallD(hz_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: architectural registers and the expected E-stage view.
    logic [31:0] rf [32];
    logic [31:0] e_rd1a, e_rd2a, e_rd1b, e_rd2b, e_imm, e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_rw, e_ld, e_v;

    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    return {i[31:12], 12'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit bp);
        if (a == 5'd0) return 32'd0;
        if (bp && RegWriteW && RdW == a) return ResultW;
        return rf[a];
    endfunction

    task automatic model_bubble();
        {e_rd1a, e_rd2a, e_rd1b, e_rd2b, e_imm, e_pc} = '0;
        {e_rs1, e_rs2, e_rd, e_rw, e_ld, e_v} = '0;
    endtask

    task automatic check_outputs();
        check_eq("rd1_bp", rd1_a, e_rd1a);   check_eq("rd2_bp", rd2_a, e_rd2a);
        check_eq("rd1_nobp", rd1_b, e_rd1b); check_eq("rd2_nobp", rd2_b, e_rd2b);
        check_eq("imm_bp", imm_a, e_imm);    check_eq("imm_nobp", imm_b, e_imm);
        check_eq("pc_bp", pc_a, e_pc);       check_eq("pc_nobp", pc_b, e_pc);
        check_eq("idx_bp", {rs1_a, rs2_a, rdx_a}, {e_rs1, e_rs2, e_rd});
        check_eq("idx_nobp", {rs1_b, rs2_b, rdx_b}, {e_rs1, e_rs2, e_rd});
        check_eq("ctl_bp", {rw_a, ld_a, v_a}, {e_rw, e_ld, e_v});
        check_eq("ctl_nobp", {rw_b, ld_b, v_b}, {e_rw, e_ld, e_v});
    endtask

    // One clock: inputs are already set (clk low); check the hazard output,
    // advance the model across the edge, then check every E output.
    task automatic cycle();
        logic        hz;
        logic [4:0]  rs1, rs2;
        logic [31:0] a1, a2, b1, b2;
        #1;
        rs1 = InstrD[19:15];
        rs2 = InstrD[24:20];
        hz  = e_ld && e_v && (e_rd != 0) && (e_rd == rs1 || e_rd == rs2);
        check_eq("hazard_bp", hz_a, hz);
        check_eq("hazard_nobp", hz_b, hz);
        a1 = ref_read(rs1, 1'b1); a2 = ref_read(rs2, 1'b1);
        b1 = ref_read(rs1, 1'b0); b2 = ref_read(rs2, 1'b0);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] = '0;
            model_bubble();
        end else begin
            if (RegWriteW && RdW != 0) rf[RdW] = ResultW;
            if (FlushE) model_bubble();
            else if (StallE) begin
                // hold
            end else if (hz) model_bubble();
            else begin
                e_rd1a = a1; e_rd2a = a2; e_rd1b = b1; e_rd2b = b2;
                e_imm = ref_imm(InstrD, ImmSrcD); e_pc = PCD;
                e_rs1 = rs1; e_rs2 = rs2; e_rd = InstrD[11:7];
                e_rw = RegWriteD; e_ld = LoadD; e_v = 1'b1;
            end
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive_d(input logic [31:0] instr, input logic [2:0] src,
                           input logic rwd, input logic ld);
        InstrD = instr; ImmSrcD = src; RegWriteD = rwd; LoadD = ld;
        PCD = PCD + 32'd4;
    endtask

    task automatic drive_w(input logic we, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = we; RdW = rd; ResultW = data;
    endtask

    logic [31:0] sv_rd1, sv_imm, sv_pc;
    logic [4:0]  sv_rd;

    initial begin
        reset = 1'b1; InstrD = '0; PCD = 32'h100; ImmSrcD = '0; RegWriteD = 0; LoadD = 0;
        drive_w(0, 0, 0); StallE = 0; FlushE = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        model_bubble();

        // Reset state.
        check_eq("reset_valid", v_a, 1'b0);
        check_eq("reset_data", {rd1_a, rd2_a, imm_a, pc_a}, '0);
        check_eq("reset_ctl", {rs1_a, rs2_a, rdx_a, rw_a, ld_a, hz_a}, '0);

        // Immediate formats.
        drive_d(32'hFFF00093, 3'd0, 1, 0); cycle();
        check_eq("imm_i", imm_a, 32'hFFFFFFFF);
        check_eq("valid_capture", v_a, 1'b1);
        drive_d(32'h123452B7, 3'd4, 1, 0); cycle();
        check_eq("imm_u", imm_a, 32'h12345000);
        drive_d(32'hFE000EE3, 3'd2, 0, 0); cycle();
        check_eq("imm_b", imm_a, 32'hFFFFFFFC);   // beq x0,x0,-4

        // Same-cycle write/read of x5.
        drive_w(1, 5'd5, 32'hDEADBEEF);
        drive_d(32'h00028093, 3'd0, 1, 0); cycle();
        check_eq("bypass_on", rd1_a, 32'hDEADBEEF);
        check_eq("bypass_off", rd1_b, 32'h0);
        drive_w(0, 0, 0); cycle();
        check_eq("after_write_bp", rd1_a, 32'hDEADBEEF);
        check_eq("after_write_nobp", rd1_b, 32'hDEADBEEF);

        // x0 writes are discarded.
        drive_w(1, 5'd0, 32'h55);
        drive_d(32'h00000093, 3'd0, 1, 0); cycle();
        check_eq("x0_same_cycle", rd1_a, 32'h0);
        drive_w(0, 0, 0); cycle();
        check_eq("x0_later", rd1_b, 32'h0);

        // Load to x0 never raises a hazard.
        drive_d(32'h00002003, 3'd0, 1, 1); cycle();
        drive_d(32'h00000093, 3'd0, 1, 0);
        #1 check_eq("x0_load_no_hazard", hz_a, 1'b0);
        cycle();

        // Load-use on rs2: lw x7 then add x8,x1,x7.
        drive_d(32'h0000A383, 3'd0, 1, 1); cycle();
        drive_d(32'h00708433, 3'd0, 1, 0);
        #1 check_eq("load_use_hazard", hz_a, 1'b1);
        cycle();
        check_eq("bubble_valid", v_a, 1'b0);
        check_eq("bubble_regwrite", rw_a, 1'b0);
        check_eq("hazard_cleared", hz_a, 1'b0);
        cycle();
        check_eq("post_bubble_capture", {v_a, rdx_a}, {1'b1, 5'd8});

        // Flush and stall together: bubble.
        FlushE = 1; StallE = 1; cycle();
        check_eq("flush_wins", {v_a, rw_a, rd1_a, imm_a, pc_a}, '0);
        FlushE = 0; StallE = 0;
        drive_d(32'h00528193, 3'd0, 1, 0); cycle();
        sv_rd1 = rd1_a; sv_imm = imm_a; sv_pc = pc_a; sv_rd = rdx_a;
        StallE = 1;
        for (int k = 0; k < 3; k++) begin
            drive_d($urandom, 3'($urandom_range(0, 4)), 0, 1);
            cycle();
            check_eq("stall_hold", {rd1_a, imm_a, pc_a, rdx_a, v_a},
                     {sv_rd1, sv_imm, sv_pc, sv_rd, 1'b1});
        end
        StallE = 0;

        // Reset mid-stream after writing x3; a write during reset is lost.
        drive_w(1, 5'd3, 32'h1234); drive_d(32'h00000013, 3'd0, 0, 0); cycle();
        reset = 1; drive_w(1, 5'd4, 32'h99); cycle();
        check_eq("midreset_outputs", {rd1_a, rd2_a, imm_a, pc_a, rdx_a, rw_a, ld_a, v_a}, '0);
        reset = 0; drive_w(0, 0, 0);
        drive_d(32'h004180B3, 3'd0, 1, 0); cycle();
        check_eq("x3_cleared", rd1_a, 32'h0);
        check_eq("x4_write_dropped", rd2_b, 32'h0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            drive_d($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) InstrD[24:20] = e_rd;
            RegWriteW = 1'($urandom_range(0, 1));
            RdW = ($urandom_range(0, 1) == 0) ? InstrD[19:15] : 5'($urandom_range(0, 31));
            ResultW = $urandom;
            FlushE = ($urandom_range(0, 15) == 0);
            StallE = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
